// File: rtl/toggle_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// toggle_pulse_conditioner
//
// Conditions a raw, bouncing, asynchronous input for the T-flip-flop counter
// chain: two-flop synchronizer, counter-qualified debounce FSM, and a
// single-cycle t_pulse on each accepted edge of the selected polarity.
//
// Parameters:
//   DB_CYCLES  consecutive stable FSM samples (minus one) needed to accept a
//              level change; legal range >= 1
//   EDGE_SEL   0 = rising, 1 = falling, 2 = both; any other value acts as 0
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   din_raw  in   raw asynchronous input (may glitch)
//   t_pulse  out  registered one-cycle pulse per accepted matching edge
//   level    out  registered debounced level
//   busy     out  registered, high while a candidate change is qualified
// -----------------------------------------------------------------------------
module toggle_pulse_conditioner #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned EDGE_SEL  = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_raw,
  output logic t_pulse,
  output logic level,
  output logic busy
);

  localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  // Unlisted EDGE_SEL values fall back to rising-only.
  localparam logic             RISE_EN  = (EDGE_SEL != 1);
  localparam logic             FALL_EN  = (EDGE_SEL == 1) || (EDGE_SEL == 2);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  // Two-flop synchronizer; the FSM only ever looks at r_s2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // A revert of r_s2 is tested before the terminal count, so a revert on the
  // same edge the count completes rejects the change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE_LO: begin
        if (r_s2) begin
          w_state_nxt = CHK_HI;
          w_cnt_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!r_s2) begin
          w_state_nxt = IDLE_LO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HI;
          w_level_nxt = 1'b1;
          w_pulse_nxt = RISE_EN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = CHK_LO;
          w_cnt_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (r_s2) begin
          w_state_nxt = IDLE_HI;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LO;
          w_level_nxt = 1'b0;
          w_pulse_nxt = FALL_EN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LO;
        w_level_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == CHK_HI) || (w_state_nxt == CHK_LO);
  end

  assign t_pulse = r_pulse;
  assign level   = r_level;
  assign busy    = r_busy;

endmodule

// File: tb/tb_toggle_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// tb_toggle_pulse_conditioner
//
// Four conditioner instances sharing clk/reset_n:
//   A: DB_CYCLES=4, EDGE_SEL=0    B: DB_CYCLES=8, EDGE_SEL=2
//   C: DB_CYCLES=2, EDGE_SEL=2 (drives a 4-bit ripple T-FF counter)
//   D: DB_CYCLES=1, EDGE_SEL=5 (out-of-range select, rising only)
// Inputs change on the falling clock edge; outputs are checked on the falling
// edge that follows each rising edge.
// -----------------------------------------------------------------------------
module tb_toggle_pulse_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din_a = 1'b0, din_b = 1'b0, din_c = 1'b0, din_d = 1'b0;
  logic tp_a, lvl_a, bsy_a;
  logic tp_b, lvl_b, bsy_b;
  logic tp_c, lvl_c, bsy_c;
  logic tp_d, lvl_d, bsy_d;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  toggle_pulse_conditioner #(.DB_CYCLES(4), .EDGE_SEL(0)) u_a (
    .clk(clk), .reset_n(reset_n), .din_raw(din_a),
    .t_pulse(tp_a), .level(lvl_a), .busy(bsy_a));
  toggle_pulse_conditioner #(.DB_CYCLES(8), .EDGE_SEL(2)) u_b (
    .clk(clk), .reset_n(reset_n), .din_raw(din_b),
    .t_pulse(tp_b), .level(lvl_b), .busy(bsy_b));
  toggle_pulse_conditioner #(.DB_CYCLES(2), .EDGE_SEL(2)) u_c (
    .clk(clk), .reset_n(reset_n), .din_raw(din_c),
    .t_pulse(tp_c), .level(lvl_c), .busy(bsy_c));
  toggle_pulse_conditioner #(.DB_CYCLES(1), .EDGE_SEL(5)) u_d (
    .clk(clk), .reset_n(reset_n), .din_raw(din_d),
    .t_pulse(tp_d), .level(lvl_d), .busy(bsy_d));

  // Ripple T-FF counter fed by instance C.
  logic [3:0] q_c;
  logic       prev_tp_c;
  int         n_back_to_back = 0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) q_c[0] <= 1'b0; else if (tp_c) q_c[0] <= ~q_c[0];
  always @(negedge q_c[0] or negedge reset_n)
    if (!reset_n) q_c[1] <= 1'b0; else q_c[1] <= ~q_c[1];
  always @(negedge q_c[1] or negedge reset_n)
    if (!reset_n) q_c[2] <= 1'b0; else q_c[2] <= ~q_c[2];
  always @(negedge q_c[2] or negedge reset_n)
    if (!reset_n) q_c[3] <= 1'b0; else q_c[3] <= ~q_c[3];

  always @(posedge clk or negedge reset_n)
    if (!reset_n) prev_tp_c <= 1'b0;
    else begin
      if (tp_c && prev_tp_c) n_back_to_back <= n_back_to_back + 1;
      prev_tp_c <= tp_c;
    end

  typedef struct {
    logic       din;
    logic [2:0] exp;   // {t_pulse, level, busy}
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic d, input logic tp, input logic lv, input logic bs,
                      input int n);
    vec_t v;
    v.din = d;
    v.exp = {tp, lv, bs};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full re-qualification on A with din_a held high from the first edge.
  task automatic requal_a(input string tag);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("%s_edge%0d", tag, k), {5'd0, tp_a, lvl_a, bsy_a},
          {5'd0, (k == 7), (k >= 7), (k >= 3 && k <= 6)});
    end
  endtask

  task automatic wait_lvl_a(input logic v, input string name);
    int k = 0;
    while (lvl_a !== v && k < 40) begin
      step();
      k++;
    end
    chk(name, {7'd0, lvl_a}, {7'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("reset_a", {5'd0, tp_a, lvl_a, bsy_a}, 8'd0);
    chk("reset_d", {5'd0, tp_d, lvl_d, bsy_d}, 8'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // ---------------- table: instance A ----------------
    // clean rise, held 20 cycles
    push(1, 0, 0, 0, 2);
    push(1, 0, 0, 1, 4);
    push(1, 1, 1, 0, 1);
    push(1, 0, 1, 0, 13);
    // clean fall, level drops on the 7th edge with no pulse
    push(0, 0, 1, 0, 2);
    push(0, 0, 1, 1, 4);
    push(0, 0, 0, 0, 4);
    // 1-sample excursion
    push(1, 0, 0, 0, 1);
    push(0, 0, 0, 0, 1);
    push(0, 0, 0, 1, 1);
    push(0, 0, 0, 0, 3);
    // 3-sample excursion
    push(1, 0, 0, 0, 2);
    push(1, 0, 0, 1, 1);
    push(0, 0, 0, 1, 2);
    push(0, 0, 0, 0, 3);
    // 4-sample excursion: revert lands on the terminal count and wins
    push(1, 0, 0, 0, 2);
    push(1, 0, 0, 1, 2);
    push(0, 0, 0, 1, 2);
    push(0, 0, 0, 0, 3);
    // 5-sample excursion: accepted, then qualified back low
    push(1, 0, 0, 0, 2);
    push(1, 0, 0, 1, 3);
    push(0, 0, 0, 1, 1);
    push(0, 1, 1, 0, 1);
    push(0, 0, 1, 1, 4);
    push(0, 0, 0, 0, 3);

    @(negedge clk);
    foreach (tbl[i]) begin
      din_a = tbl[i].din;
      step();
      chk($sformatf("tbl_a[%0d]", i), {5'd0, tp_a, lvl_a, bsy_a}, {5'd0, tbl[i].exp});
    end

    // ---------------- async reset while level=1 ----------------
    din_a = 1'b1;
    wait_lvl_a(1'b1, "a_pre_reset_level");
    #2 reset_n = 1'b0;
    #1 chk("a_async_reset", {5'd0, tp_a, lvl_a, bsy_a}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("a_reset_held", {5'd0, tp_a, lvl_a, bsy_a}, 8'd0);
    reset_n = 1'b1;
    requal_a("a_requal1");

    // ---------------- reset mid-qualification ----------------
    din_a = 1'b0;
    wait_lvl_a(1'b0, "a_drop_level");
    repeat (3) step();
    din_a = 1'b1;
    repeat (5) step();   // CHK_HI with cnt=2
    chk("a_mid_busy", {5'd0, tp_a, lvl_a, bsy_a}, 8'b001);
    #2 reset_n = 1'b0;
    #1 chk("a_mid_reset", {5'd0, tp_a, lvl_a, bsy_a}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    requal_a("a_requal2");
    din_a = 1'b0;

    // ---------------- bounce burst on B ----------------
    for (int k = 1; k <= 45; k++) begin
      din_b = (k <= 30) ? logic'(((k - 1) / 2) % 2) : 1'b1;
      step();
      chk($sformatf("b_bounce_%0d", k), {6'd0, tp_b, lvl_b},
          {6'd0, (k == 41), (k >= 41)});
    end
    for (int k = 1; k <= 14; k++) begin
      din_b = 1'b0;
      step();
      chk($sformatf("b_fall_%0d", k), {6'd0, tp_b, lvl_b},
          {6'd0, (k == 11), (k < 11)});
    end

    // ---------------- both-edge mode into the T-FF chain ----------------
    chk("c_count_start", {4'd0, q_c}, 8'd0);
    for (int p = 0; p < 5; p++) begin
      din_c = 1'b1;
      repeat (8) step();
      din_c = 1'b0;
      repeat (8) step();
    end
    repeat (4) step();
    chk("c_count_10", {4'd0, q_c}, 8'd10);
    chk("c_level_low", {7'd0, lvl_c}, 8'd0);
    chk("c_no_back_to_back", n_back_to_back[7:0], 8'd0);

    // ---------------- DB_CYCLES=1, out-of-range EDGE_SEL ----------------
    for (int k = 1; k <= 5; k++) begin
      din_d = (k == 1);
      step();
      chk($sformatf("d_glitch_%0d", k), {5'd0, tp_d, lvl_d, bsy_d},
          {5'd0, 1'b0, 1'b0, (k == 3)});
    end
    for (int k = 1; k <= 6; k++) begin
      din_d = 1'b1;
      step();
      chk($sformatf("d_rise_%0d", k), {5'd0, tp_d, lvl_d, bsy_d},
          {5'd0, (k == 4), (k >= 4), (k == 3)});
    end
    for (int k = 1; k <= 6; k++) begin
      din_d = 1'b0;
      step();
      chk($sformatf("d_fall_%0d", k), {5'd0, tp_d, lvl_d, bsy_d},
          {5'd0, 1'b0, (k < 4), (k == 3)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
